// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready flow control, MEM-side stall,
// late kill from branch resolution, and the MEM-stage forwarding tap.
// Optional performance counters are enabled by defining EX_MEM_PERF_EN;
// without it perf_bubbles/perf_stalls are tied to zero.
module ex_mem_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // EX side
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [XLEN-1:0]   ex_alu_res,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [4:0]        ex_rd,
  // branch resolution
  input  logic              kill,
  // MEM side
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [XLEN-1:0]   mem_alu_res,
  output logic [XLEN-1:0]   mem_store_data,
  output logic [XLEN-1:0]   mem_pc_plus4,
  output logic [4:0]        mem_rd,
  // forwarding tap
  output logic              fwd_we,
  output logic [4:0]        fwd_rd,
  // performance counters
  output logic [CNT_W-1:0]  perf_bubbles,
  output logic [CNT_W-1:0]  perf_stalls
);

  // Control-word bit carrying reg_write.
  localparam int CtrlRegWrite = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entry toward MEM
    FULL  = 2'd1,  // entry presented
    HOLD  = 2'd2   // entry presented, MEM refused it on the last edge
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [XLEN-1:0]     alu_res_q, alu_res_d;
  logic [XLEN-1:0]     store_data_q, store_data_d;
  logic [XLEN-1:0]     pc_plus4_q, pc_plus4_d;
  logic [4:0]          rd_q, rd_d;

  logic                valid_q;
  logic                load;
  logic                bubble_seen;

  assign valid_q  = (state_q != EMPTY);
  assign ex_ready = !valid_q || mem_ready;

  // A zero control word is a bubble and never occupies the register.
  assign load        = ex_valid && ex_ready && !kill && (ex_ctrl != '0);
  assign bubble_seen = ex_valid && ex_ready && (ex_ctrl == '0);

  // Next-state and next-entry selection; kill overrides load and stall.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    alu_res_d    = alu_res_q;
    store_data_d = store_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;

    if (kill) begin
      // Squash: control cleared so nothing stale reaches MEM; data fields
      // keep their value since they are ignored while invalid.
      state_d = EMPTY;
      ctrl_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (load) state_d = FULL;
        end
        FULL, HOLD: begin
          if (mem_ready) state_d = load ? FULL : EMPTY;
          else           state_d = HOLD;
        end
        default: state_d = EMPTY;
      endcase

      if (load) begin
        ctrl_d       = ex_ctrl;
        alu_res_d    = ex_alu_res;
        store_data_d = ex_store_data;
        pc_plus4_d   = ex_pc_plus4;
        rd_d         = ex_rd;
      end else if (state_d == EMPTY) begin
        ctrl_d = '0;
      end
    end
  end

  // State and entry registers; reset empties the stage and zeroes the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= EMPTY;
      ctrl_q       <= '0;
      alu_res_q    <= '0;
      store_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      alu_res_q    <= alu_res_d;
      store_data_q <= store_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_ctrl       = ctrl_q;
  assign mem_alu_res    = alu_res_q;
  assign mem_store_data = store_data_q;
  assign mem_pc_plus4   = pc_plus4_q;
  assign mem_rd         = rd_q;

  // Writes to x0 are never forwarded.
  assign fwd_we = valid_q && ctrl_q[CtrlRegWrite] && (rd_q != 5'd0);
  assign fwd_rd = rd_q;

`ifdef EX_MEM_PERF_EN
  logic [CNT_W-1:0] bubbles_q, stalls_q;

  // Saturating event counters for bubbles offered and cycles spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbles_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (bubble_seen && (bubbles_q != '1))
        bubbles_q <= bubbles_q + 1'b1;
      if ((state_q == HOLD) && (stalls_q != '1))
        stalls_q <= stalls_q + 1'b1;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_stalls  = stalls_q;
`else
  logic unused_perf;
  assign unused_perf  = bubble_seen;
  assign perf_bubbles = '0;
  assign perf_stalls  = '0;
`endif

endmodule
